// File: rtl/rgb_pwm_if.sv
// rgb_pwm_if: groups the run control, colour input and LED outputs of the
// RGB PWM driver. The driver connects through the slave modport; whatever
// produces the colour and enable uses the master modport.
interface rgb_pwm_if;
  logic        enable;
  logic [23:0] light;
  logic        pwm_r;
  logic        pwm_g;
  logic        pwm_b;
  logic        frame_start;

  modport master (
    output enable,
    output light,
    input  pwm_r,
    input  pwm_g,
    input  pwm_b,
    input  frame_start
  );

  modport slave (
    input  enable,
    input  light,
    output pwm_r,
    output pwm_g,
    output pwm_b,
    output frame_start
  );
endinterface

// File: rtl/rgb_pwm_driver.sv
// rgb_pwm_driver: three-channel LED PWM engine.
// A prescaler divides clk into PWM ticks, and an 8-bit phase counter runs
// 0..254, so one frame is 255 ticks. Each channel drives high while
// phase < duty. Duty registers change only at a frame boundary, or on every
// cycle while the engine is stopped.
// Optional build macro PWM_FADE_EN: at each frame boundary, every duty
// register steps by one toward its light channel instead of loading it.
// Reset (rst) is asynchronous and active-low.
module rgb_pwm_driver #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic       clk,
  input  logic       rst,
  rgb_pwm_if.slave   bus
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    phase_q, phase_d;
  logic          en_q, en_d;    // engine was running during the previous cycle
  logic          fs_q, fs_d;    // frame_start pulse register
  logic          tick;
  logic          wrap;
  logic [2:0]    pwm_vec;       // [0]=red, [1]=green, [2]=blue

  assign tick = (presc_q == PRESC_MAX);
  assign wrap = en_q && tick && (phase_q == 8'd254);

  // Next state of the prescaler, phase counter and frame_start pulse
  always_comb begin
    en_d    = bus.enable;
    presc_d = presc_q;
    phase_d = phase_q;
    fs_d    = 1'b0;
    if (!bus.enable) begin
      presc_d = '0;
      phase_d = '0;
    end else if (!en_q) begin
      // first enabled cycle: begin a fresh frame at phase 0
      presc_d = '0;
      phase_d = '0;
      fs_d    = 1'b1;
    end else begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      if (tick) begin
        phase_d = (phase_q == 8'd254) ? 8'd0 : phase_q + 8'd1;
      end
      fs_d = wrap;
    end
  end

  // Timing state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
      phase_q <= '0;
      en_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      presc_q <= presc_d;
      phase_q <= phase_d;
      en_q    <= en_d;
      fs_q    <= fs_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_ch
      logic [7:0] light_ch;
      logic [7:0] duty_q, duty_d;

      assign light_ch = bus.light[23-8*gi -: 8];

      // Duty update: follow light while stopped, else change only at a frame boundary
      always_comb begin
        duty_d = duty_q;
        if (!bus.enable) begin
          duty_d = light_ch;
        end else if (wrap) begin
`ifdef PWM_FADE_EN
          if (duty_q < light_ch) begin
            duty_d = duty_q + 8'd1;
          end else if (duty_q > light_ch) begin
            duty_d = duty_q - 8'd1;
          end
`else
          duty_d = light_ch;
`endif
        end
      end

      // Duty register
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          duty_q <= '0;
        end else begin
          duty_q <= duty_d;
        end
      end

      // Output depends on registered state only, so it cannot glitch on input changes
      assign pwm_vec[gi] = en_q & (phase_q < duty_q);
    end
  endgenerate

  assign bus.pwm_r       = pwm_vec[0];
  assign bus.pwm_g       = pwm_vec[1];
  assign bus.pwm_b       = pwm_vec[2];
  assign bus.frame_start = fs_q;

endmodule
